cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of functional-unit result sources.
REQ-002 SHALL have parameter REG_FILE_ADDR_WIDTH, default 7: width of a physical-register tag.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: width of a result value.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all pending results (mispredict).
REQ-007 SHALL have port src_valid  input  NUM_SRC  per-source result-offer strobe.
REQ-008 SHALL have port src_ready  output  NUM_SRC  per-source accept indication.
REQ-009 SHALL have port src_tag  input  NUM_SRC*REG_FILE_ADDR_WIDTH  packed destination tags; source i occupies slice i.
REQ-010 SHALL have port src_data  input  NUM_SRC*DATA_WIDTH  packed result values; source i occupies slice i.
REQ-011 SHALL have port cdb_valid  output  1  broadcast strobe to reservation stations and register file.
REQ-012 SHALL have port cdb_tag  output  REG_FILE_ADDR_WIDTH  broadcast destination tag.
REQ-013 SHALL have port cdb_data  output  DATA_WIDTH  broadcast result value.

Function
REQ-014 SHALL hold one pending slot per source (valid bit, tag, data).
REQ-015 SHALL drive src_ready[i] = !flush && (!pend[i] || grant[i]), combinationally.
REQ-016 SHALL capture src_tag/src_data slice i into slot i on a rising edge where src_valid[i] && src_ready[i], setting pend[i].
REQ-017 SHALL accept an offer with tag 0 (x0) but discard it: pend[i] not set, never broadcast.
REQ-018 SHALL each cycle grant exactly one pending source when any pend bit is set, and grant none otherwise.
REQ-019 SHALL, on the edge after a grant, register the winner's tag/data onto cdb_tag/cdb_data, assert cdb_valid, and clear the winner's pend bit unless it is refilled on that same edge.
REQ-020 SHALL hold cdb_valid high for exactly one cycle per grant; back-to-back grants yield consecutive single-cycle broadcasts.
REQ-021 SHALL give a latency of two edges from handshake to broadcast: captured at edge k, cdb_valid high after edge k+1, absent contention.
REQ-022 SHALL give simultaneous grant and refill of the same source: new data occupies the slot, old data broadcast, no loss.
REQ-023 SHALL hold cdb_tag/cdb_data stable at their last values while cdb_valid is low.
REQ-024 SHALL, when flush is high at an edge, clear all pend bits and deassert cdb_valid; no grant or capture takes effect on that edge.
REQ-025 SHALL sustain a throughput of one broadcast per cycle while any pend bit is set.

Reset
REQ-026 SHALL, while reset is low, asynchronously clear all pend bits, cdb_valid=0, cdb_tag=0, cdb_data=0, and priority pointer=0.
REQ-027 SHALL discard all in-flight results when reset asserts mid-operation; first possible broadcast is two edges after the first post-reset handshake.

Configuration
REQ-028 SHALL support macro CDB_ROUND_ROBIN_EN.
REQ-029 SHALL, with CDB_ROUND_ROBIN_EN defined, search from priority pointer p upward modulo NUM_SRC, and set p = (winner+1) mod NUM_SRC after each grant; p is unchanged when no grant or on flush.
REQ-030 SHALL, with CDB_ROUND_ROBIN_EN undefined, use fixed priority (lowest index wins); no pointer state is implemented.

Verification
REQ-031 SHALL cover: single offer src1 tag=0x15 data=0xDEADBEEF at edge 3 -> cdb_valid high after edge 4 only, cdb_tag=0x15, cdb_data=0xDEADBEEF.
REQ-032 SHALL cover: all four sources offer at one edge with tags 0x11-0x14, CDB_ROUND_ROBIN_EN defined, p=0 -> four consecutive broadcasts in order 0x11, 0x12, 0x13, 0x14, then p=0.
REQ-033 SHALL cover: same stimulus without CDB_ROUND_ROBIN_EN while src0 re-offers every cycle -> src0 tags broadcast continuously, src3 never granted until src0 stops.
REQ-034 SHALL cover: src2 pending with tag 0x20 and granted while offering tag 0x21 on the same edge -> broadcast 0x20, then 0x21 next cycle, src_ready[2] stays high.
REQ-035 SHALL cover: offer with tag 0 on src0 -> src_ready[0]=1, no cdb_valid pulse ever.
REQ-036 SHALL cover: three sources pending, flush high one cycle -> cdb_valid=0 next cycle, all src_ready low during flush, no stale broadcast afterwards; reset low mid-burst -> outputs 0 immediately.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one pending slot per functional-unit source, one broadcast per cycle.
// Define CDB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest-indexed pending source wins.
module cdb_arbiter #(
  parameter int NUM_SRC             = 4,
  parameter int REG_FILE_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH          = 32
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [NUM_SRC-1:0]                     src_valid,
  output logic [NUM_SRC-1:0]                     src_ready,
  input  logic [NUM_SRC*REG_FILE_ADDR_WIDTH-1:0] src_tag,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]          src_data,
  output logic                                   cdb_valid,
  output logic [REG_FILE_ADDR_WIDTH-1:0]         cdb_tag,
  output logic [DATA_WIDTH-1:0]                  cdb_data
);

  localparam int AW    = REG_FILE_ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [AW-1:0]      tag_q  [NUM_SRC];
  logic [AW-1:0]      tag_d  [NUM_SRC];
  logic [DW-1:0]      data_q [NUM_SRC];
  logic [DW-1:0]      data_d [NUM_SRC];

  logic               cdb_valid_q, cdb_valid_d;
  logic [AW-1:0]      cdb_tag_q, cdb_tag_d;
  logic [DW-1:0]      cdb_data_q, cdb_data_d;

  logic               any_grant;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_SRC-1:0] grant;

`ifdef CDB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    any_grant = 1'b0;
    win_idx   = '0;
    cand      = '0;
    grant     = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand = IDX_W'((int'(ptr_q) + off) % NUM_SRC);
      if (!any_grant && pend_q[cand]) begin
        any_grant = 1'b1;
        win_idx   = cand;
      end
    end
    if (any_grant) grant[win_idx] = 1'b1;
  end

  // The pointer only moves on a grant that actually takes effect.
  always_comb begin
    ptr_d = ptr_q;
    if (!flush && any_grant) begin
      ptr_d = (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    any_grant = 1'b0;
    win_idx   = '0;
    grant     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        any_grant = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    if (any_grant) grant[win_idx] = 1'b1;
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !flush && (!pend_q[i] || grant[i]);
    end
  end

  // Refill is applied after the winner's clear so a same-edge refill keeps the slot occupied.
  always_comb begin
    pend_d      = pend_q;
    tag_d       = tag_q;
    data_d      = data_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (any_grant) begin
        cdb_valid_d      = 1'b1;
        cdb_tag_d        = tag_q[win_idx];
        cdb_data_d       = data_q[win_idx];
        pend_d[win_idx]  = 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i] && (src_tag[i*AW +: AW] != '0)) begin
          pend_d[i] = 1'b1;
          tag_d[i]  = src_tag[i*AW +: AW];
          data_d[i] = src_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule
